// File: rtl/doodle_motion.sv
// Per-frame player motion for Doodle Jump: gravity, bounce, wrap, camera scroll and death.
// Everything advances once per frame_clk edge; Reset is asynchronous and active-high.
module doodle_motion #(
    parameter int X_CENTER     = 320,
    parameter int Y_CENTER     = 240,
    parameter int X_MAX        = 639,
    parameter int Y_FLOOR      = 479,
    parameter int SIZE         = 4,
    parameter int GRAVITY      = 1,
    parameter int GRAV_DIV     = 4,
    parameter int JUMP_VEL     = 12,
    parameter int MAX_FALL     = 8,
    parameter int X_SPEED      = 2,
    parameter int SCROLL_LINE  = 160,
    parameter int FLOOR_BOUNCE = 0
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    input  logic [1:0]        game_state,
    input  logic              on_platform,
    output logic [9:0]        BallX,
    output logic [9:0]        BallY,
    output logic [9:0]        BallS,
    output logic signed [7:0] vel_y,
    output logic [9:0]        scroll,
    output logic              rising,
    output logic              fell_out
);

    localparam int CntW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    localparam logic [9:0]         XCenter    = 10'(X_CENTER);
    localparam logic [9:0]         YCenter    = 10'(Y_CENTER);
    localparam logic [9:0]         YRest      = 10'(Y_FLOOR - SIZE);
    localparam logic signed [10:0] XMaxS      = 11'(X_MAX);
    localparam logic signed [10:0] XModS      = 11'(X_MAX + 1);
    localparam logic signed [10:0] XSpeedS    = 11'(X_SPEED);
    localparam logic signed [10:0] ScrollS    = 11'(SCROLL_LINE);
    localparam logic signed [11:0] FloorS     = 12'(Y_FLOOR);
    localparam logic signed [11:0] SizeS      = 12'(SIZE);
    localparam logic signed [7:0]  JumpNeg    = 8'(-JUMP_VEL);
    localparam logic signed [8:0]  GravS      = 9'(GRAVITY);
    localparam logic signed [8:0]  MaxFallS   = 9'(MAX_FALL);
    localparam logic [CntW-1:0]    CntLast    = CntW'(GRAV_DIV - 1);

    typedef enum logic [1:0] {
        StMenu,
        StFall,
        StRise,
        StDead
    } state_t;

    state_t                r_state;
    logic [9:0]            r_x;
    logic [9:0]            r_y;
    logic signed [7:0]     r_vel;
    logic [CntW-1:0]       r_cnt;
    logic [9:0]            r_scroll;
    logic                  r_fell;

    state_t                w_state_d;
    logic [9:0]            w_x_d;
    logic [9:0]            w_y_d;
    logic signed [7:0]     w_vel_d;
    logic [CntW-1:0]       w_cnt_d;
    logic [9:0]            w_scroll_d;
    logic                  w_fell_d;

    logic signed [10:0]    w_y_next;
    logic signed [11:0]    w_y_foot;
    logic signed [10:0]    w_x_step;
    logic signed [10:0]    w_x_next;
    logic                  w_key_right;
    logic                  w_key_left;
    logic                  w_grav_wrap;
    logic [CntW-1:0]       w_cnt_inc;
    logic signed [8:0]     w_vel_sum;
    logic signed [7:0]     w_vel_grav;
    logic                  w_plat_bounce;
    logic                  w_floor_hit;
    logic                  w_scroll_hit;
    logic                  w_playing;

    // Vertical datapath
    assign w_y_next   = $signed({1'b0, r_y}) + $signed({{3{r_vel[7]}}, r_vel});
    assign w_y_foot   = $signed({w_y_next[10], w_y_next}) + SizeS;

    assign w_grav_wrap = (r_cnt == CntLast);
    assign w_cnt_inc   = w_grav_wrap ? '0 : r_cnt + CntW'(1);
    assign w_vel_sum   = $signed({r_vel[7], r_vel}) + GravS;

    always_comb begin
        w_vel_grav = r_vel;
        if (w_grav_wrap) begin
            if (w_vel_sum > MaxFallS) begin
                w_vel_grav = MaxFallS[7:0];
            end else begin
                w_vel_grav = w_vel_sum[7:0];
            end
        end
    end

    assign w_plat_bounce = (r_state == StFall) && !r_vel[7] && on_platform;
    assign w_floor_hit   = (r_state == StFall) && (w_y_foot >= FloorS);
    assign w_scroll_hit  = r_vel[7] && (w_y_next < ScrollS);

    // Horizontal datapath with screen wrap
    assign w_key_right = (keycode == 8'd7) || (keycode == 8'd79);
    assign w_key_left  = (keycode == 8'd4) || (keycode == 8'd80);

    always_comb begin
        w_x_step = $signed({1'b0, r_x});
        if (w_key_right) begin
            w_x_step = $signed({1'b0, r_x}) + XSpeedS;
        end else if (w_key_left) begin
            w_x_step = $signed({1'b0, r_x}) - XSpeedS;
        end
    end

    always_comb begin
        w_x_next = w_x_step;
        if (w_x_step < 11'sd0) begin
            w_x_next = w_x_step + XModS;
        end else if (w_x_step > XMaxS) begin
            w_x_next = w_x_step - XModS;
        end
    end

    assign w_playing = (game_state == 2'd1);

    // Next-state and register updates
    always_comb begin
        w_state_d  = r_state;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_vel_d    = r_vel;
        w_cnt_d    = r_cnt;
        w_scroll_d = r_scroll;
        w_fell_d   = 1'b0;

        if (game_state == 2'd0) begin
            w_state_d  = StMenu;
            w_x_d      = XCenter;
            w_y_d      = YCenter;
            w_vel_d    = '0;
            w_cnt_d    = '0;
            w_scroll_d = '0;
        end else begin
            unique case (r_state)
                StMenu: begin
                    if (w_playing) begin
                        w_state_d = StFall;
                        w_vel_d   = '0;
                        w_cnt_d   = '0;
                    end
                end
                StFall, StRise: begin
                    if (!w_playing) begin
                        w_scroll_d = '0;
                    end else begin
                        w_x_d      = w_x_next[9:0];
                        w_scroll_d = '0;
                        // A platform contact outranks the floor, so it never kills
                        if (w_plat_bounce || (w_floor_hit && (FLOOR_BOUNCE != 0))) begin
                            w_state_d = StRise;
                            w_vel_d   = JumpNeg;
                            w_cnt_d   = '0;
                            w_y_d     = w_plat_bounce ? w_y_next[9:0] : YRest;
                        end else if (w_floor_hit) begin
                            w_state_d = StDead;
                            w_vel_d   = '0;
                            w_cnt_d   = w_cnt_inc;
                            w_y_d     = YRest;
                            w_fell_d  = 1'b1;
                        end else begin
                            w_vel_d = w_vel_grav;
                            w_cnt_d = w_cnt_inc;
                            if (w_scroll_hit) begin
                                w_y_d      = ScrollS[9:0];
                                w_scroll_d = 10'(ScrollS - w_y_next);
                            end else begin
                                w_y_d = w_y_next[9:0];
                            end
                            if ((r_state == StRise) && !w_vel_grav[7]) begin
                                w_state_d = StFall;
                            end
                        end
                    end
                end
                StDead: begin
                    w_state_d = StDead;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= StMenu;
            r_x      <= XCenter;
            r_y      <= YCenter;
            r_vel    <= '0;
            r_cnt    <= '0;
            r_scroll <= '0;
            r_fell   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_vel    <= w_vel_d;
            r_cnt    <= w_cnt_d;
            r_scroll <= w_scroll_d;
            r_fell   <= w_fell_d;
        end
    end

    assign BallX    = r_x;
    assign BallY    = r_y;
    assign BallS    = 10'(SIZE);
    assign vel_y    = r_vel;
    assign scroll   = r_scroll;
    assign rising   = (r_state == StRise);
    assign fell_out = r_fell;

endmodule
